// File: rtl/arp_pkg.sv
// Shared definitions for the ARP transmit sequencing controller:
// FSM state type, ARP opcodes and default timing values.
package arp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_RPL,
        ST_ISSUE_REQ,
        ST_WAIT_TX,
        ST_WAIT_RESP
    } arp_state_t;

    localparam logic [15:0] ARP_OP_REQUEST = 16'd1;
    localparam logic [15:0] ARP_OP_REPLY   = 16'd2;

    localparam logic [31:0] DEF_TIMEOUT_CYC = 32'd156_250_000;
    localparam logic [3:0]  DEF_MAX_RETRY   = 4'd3;
    localparam int unsigned DEF_CNT_W       = 32;

endpackage

// File: rtl/arp_tx_ctrl_if.sv
// Requester, framer-trigger, framer-monitor and status signals of arp_tx_ctrl.
// master = the controller, slave = its environment.
interface arp_tx_ctrl_if;

    logic        i_reply_req;
    logic        i_lookup_req;
    logic [31:0] i_lookup_ip;
    logic        o_lookup_busy;
    logic        i_resolve_valid;
    logic [31:0] i_resolve_ip;
    logic [31:0] i_src_ip;
    logic        o_arp_reply;
    logic        o_arp_active;
    logic [31:0] o_arp_active_dst_ip;
    logic        i_tx_valid;
    logic        i_tx_last;
    logic        i_tx_ready;
    logic        o_resolved;
    logic        o_resolve_fail;
    logic [3:0]  o_retry_cnt;

    modport master (
        input  i_reply_req, i_lookup_req, i_lookup_ip, i_resolve_valid,
               i_resolve_ip, i_src_ip, i_tx_valid, i_tx_last, i_tx_ready,
        output o_lookup_busy, o_arp_reply, o_arp_active, o_arp_active_dst_ip,
               o_resolved, o_resolve_fail, o_retry_cnt
    );

    modport slave (
        output i_reply_req, i_lookup_req, i_lookup_ip, i_resolve_valid,
               i_resolve_ip, i_src_ip, i_tx_valid, i_tx_last, i_tx_ready,
        input  o_lookup_busy, o_arp_reply, o_arp_active, o_arp_active_dst_ip,
               o_resolved, o_resolve_fail, o_retry_cnt
    );

endinterface

// File: rtl/arp_retry_timer.sv
// Reply timeout counter: start arms it from zero, clear disarms it; expiry is
// sticky so a timeout that lands during a reply detour is not lost.
module arp_retry_timer
    import arp_pkg::*;
#(
    parameter int unsigned P_CNT_W       = DEF_CNT_W,
    parameter logic [31:0] P_TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam logic [P_CNT_W-1:0] LAST = P_CNT_W'(P_TIMEOUT_CYC - 32'd1);

    logic [P_CNT_W-1:0] cnt;
    logic               run;
    logic               held;
    logic               hit;

    assign hit     = run && (cnt == LAST);
    assign expired = hit || held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            run  <= 1'b0;
            held <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            run  <= 1'b0;
            held <= 1'b0;
        end else if (start) begin
            cnt  <= '0;
            run  <= 1'b1;
            held <= 1'b0;
        end else if (hit) begin
            run  <= 1'b0;
            held <= 1'b1;
        end else if (run) begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/arp_tx_ctrl.sv
// ARP transmit sequencer: arbitrates replies and requests onto the framer
// trigger, runs request timeout/retry. Optional macro: ARP_GRATUITOUS_EN.
module arp_tx_ctrl
    import arp_pkg::*;
#(
    parameter logic [31:0] P_TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter logic [3:0]  P_MAX_RETRY   = DEF_MAX_RETRY,
    parameter int unsigned P_CNT_W       = DEF_CNT_W
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    arp_tx_ctrl_if.master bus
);

    arp_state_t  state, nxt;
    logic        reply_pend, req_pend, req_out, busy, req_frame;
    logic [3:0]  retry;
    logic [31:0] dst;
    logic        resolved_q, fail_q;
    logic        frame_done, tx_done, resolve_hit, lookup_acc;
    logic        do_retry, do_fail, tmr_start, tmr_clear, tmr_expired;
    logic        boot, grat;

`ifdef ARP_GRATUITOUS_EN
    logic boot_q, grat_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            boot_q <= 1'b1;
            grat_q <= 1'b0;
        end else begin
            boot_q <= 1'b0;
            if (boot_q)
                grat_q <= 1'b1;
            else if (tx_done)
                grat_q <= 1'b0;
        end
    end

    assign boot = boot_q;
    assign grat = boot_q || grat_q;
`else
    logic unused_src_ip;
    assign unused_src_ip = ^bus.i_src_ip;
    assign boot = 1'b0;
    assign grat = 1'b0;
`endif

    assign frame_done  = bus.i_tx_valid && bus.i_tx_ready && bus.i_tx_last;
    assign tx_done     = (state == ST_WAIT_TX) && frame_done;
    assign resolve_hit = bus.i_resolve_valid && (bus.i_resolve_ip == dst) && req_out;
    assign lookup_acc  = bus.i_lookup_req && !busy && !boot;
    assign tmr_clear   = resolve_hit || do_retry || do_fail;

    arp_retry_timer #(
        .P_CNT_W       (P_CNT_W),
        .P_TIMEOUT_CYC (P_TIMEOUT_CYC)
    ) u_timer (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (tmr_start),
        .clear   (tmr_clear),
        .expired (tmr_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    // After a frame, only wait for a response once the request has actually
    // been sent; a still-pending request goes back through IDLE to issue.
    always_comb begin
        nxt       = state;
        do_retry  = 1'b0;
        do_fail   = 1'b0;
        tmr_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_tx_ready) begin
                    if (reply_pend && !grat)
                        nxt = ST_ISSUE_RPL;
                    else if (req_pend && !resolve_hit)
                        nxt = ST_ISSUE_REQ;
                end
            end
            ST_ISSUE_RPL: nxt = ST_WAIT_TX;
            ST_ISSUE_REQ: nxt = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (frame_done) begin
                    if (req_out && !req_pend && !resolve_hit) begin
                        nxt       = ST_WAIT_RESP;
                        tmr_start = req_frame;
                    end else begin
                        nxt = ST_IDLE;
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (resolve_hit || !req_out) begin
                    nxt = ST_IDLE;
                end else if (reply_pend && bus.i_tx_ready) begin
                    nxt = ST_ISSUE_RPL;
                end else if (tmr_expired) begin
                    nxt = ST_IDLE;
                    if (retry < P_MAX_RETRY)
                        do_retry = 1'b1;
                    else
                        do_fail = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reply_pend <= 1'b0;
            req_pend   <= 1'b0;
            req_out    <= 1'b0;
            busy       <= 1'b0;
            req_frame  <= 1'b0;
            retry      <= '0;
            dst        <= '0;
            resolved_q <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            reply_pend <= (reply_pend || bus.i_reply_req) && (state != ST_ISSUE_RPL);

            if (boot || lookup_acc)
                req_pend <= 1'b1;
            else if ((state == ST_ISSUE_REQ) || resolve_hit)
                req_pend <= 1'b0;
            else if (do_retry)
                req_pend <= 1'b1;

            if (lookup_acc)
                req_out <= 1'b1;
            else if (resolve_hit || do_fail)
                req_out <= 1'b0;

            if (boot || lookup_acc)
                busy <= 1'b1;
            else if (resolve_hit || do_fail || (grat && tx_done))
                busy <= 1'b0;

            if (state == ST_ISSUE_REQ)
                req_frame <= 1'b1;
            else if (state == ST_ISSUE_RPL)
                req_frame <= 1'b0;

            if (lookup_acc)
                retry <= '0;
            else if (do_retry)
                retry <= retry + 4'd1;

            if (boot)
                dst <= bus.i_src_ip;
            else if (lookup_acc)
                dst <= bus.i_lookup_ip;

            resolved_q <= resolve_hit;
            fail_q     <= do_fail;
        end
    end

    assign bus.o_lookup_busy       = busy;
    assign bus.o_arp_reply         = (state == ST_ISSUE_RPL);
    assign bus.o_arp_active        = (state == ST_ISSUE_REQ);
    assign bus.o_arp_active_dst_ip = dst;
    assign bus.o_resolved          = resolved_q;
    assign bus.o_resolve_fail      = fail_q;
    assign bus.o_retry_cnt         = retry;

endmodule

// File: tb/tb_arp_tx_ctrl.sv
// Directed bench for arp_tx_ctrl (timeout 100 cycles, 2 retries) with a
// 4-beat framer model that counts triggers and status pulses.
module tb_arp_tx_ctrl;

    localparam int FRAME_LEN = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arp_tx_ctrl_if bus ();

    arp_tx_ctrl #(
        .P_TIMEOUT_CYC (32'd100),
        .P_MAX_RETRY   (4'd2),
        .P_CNT_W       (32)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int rpl_cnt     = 0;
    int act_cnt     = 0;
    int res_cnt     = 0;
    int fail_cnt    = 0;
    int overlap     = 0;
    int base_a, base_r, base_f, base_s;

    // Framer model: a trigger starts a FRAME_LEN-beat frame with last on the final beat.
    initial begin
        int left;
        left = 0;
        bus.i_tx_valid = 1'b0;
        bus.i_tx_last  = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_tx_valid = 1'b0;
            bus.i_tx_last  = 1'b0;
            if (!rst_n) begin
                left = 0;
            end else begin
                if (bus.o_arp_reply || bus.o_arp_active) begin
                    if (left > 0) overlap++;
                    if (bus.o_arp_reply)  rpl_cnt++;
                    if (bus.o_arp_active) act_cnt++;
                    left = FRAME_LEN;
                end else if (left > 0) begin
                    left--;
                    bus.i_tx_valid = 1'b1;
                    bus.i_tx_last  = (left == 0);
                end
                if (bus.o_resolved)     res_cnt++;
                if (bus.o_resolve_fail) fail_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.i_reply_req     = 1'b0;
        bus.i_lookup_req    = 1'b0;
        bus.i_lookup_ip     = '0;
        bus.i_resolve_valid = 1'b0;
        bus.i_resolve_ip    = '0;
        bus.i_src_ip        = 32'h0A0000FE;
        bus.i_tx_ready      = 1'b1;

        // reset values
        ticks(3);
        chk("rst_reply",  32'(bus.o_arp_reply), 0);
        chk("rst_active", 32'(bus.o_arp_active), 0);
        chk("rst_busy",   32'(bus.o_lookup_busy), 0);
        chk("rst_dst",    bus.o_arp_active_dst_ip, 0);
        chk("rst_res",    32'(bus.o_resolved), 0);
        chk("rst_fail",   32'(bus.o_resolve_fail), 0);
        chk("rst_retry",  32'(bus.o_retry_cnt), 0);
        rst_n = 1'b1;
        ticks(2);

        // reply latency: trigger two cycles after the request pulse, once only
        bus.i_reply_req = 1'b1;
        tick();
        bus.i_reply_req = 1'b0;
        chk("rpl_lat1", 32'(bus.o_arp_reply), 0);
        tick();
        chk("rpl_fire", 32'(bus.o_arp_reply), 1);
        tick();
        chk("rpl_once", 32'(bus.o_arp_reply), 0);
        ticks(10);
        chk("rpl_cnt1", rpl_cnt, 1);

        // lookup, mismatching resolve ignored, matching resolve clears busy
        base_a = act_cnt;
        bus.i_lookup_req = 1'b1;
        bus.i_lookup_ip  = 32'hC0A86401;
        tick();
        bus.i_lookup_req = 1'b0;
        chk("lk_busy",  32'(bus.o_lookup_busy), 1);
        chk("lk_dst",   bus.o_arp_active_dst_ip, 32'hC0A86401);
        chk("lk_retry", 32'(bus.o_retry_cnt), 0);
        ticks(19);
        bus.i_resolve_valid = 1'b1;
        bus.i_resolve_ip    = 32'hC0A86402;
        tick();
        bus.i_resolve_valid = 1'b0;
        chk("res_mismatch", 32'(bus.o_resolved), 0);
        chk("res_mm_busy",  32'(bus.o_lookup_busy), 1);
        tick();
        bus.i_resolve_valid = 1'b1;
        bus.i_resolve_ip    = 32'hC0A86401;
        tick();
        bus.i_resolve_valid = 1'b0;
        chk("res_pulse", 32'(bus.o_resolved), 1);
        chk("res_busy",  32'(bus.o_lookup_busy), 0);
        chk("res_retry", 32'(bus.o_retry_cnt), 0);
        tick();
        chk("res_once", 32'(bus.o_resolved), 0);
        ticks(150);
        chk("res_act",  act_cnt, base_a + 1);
        chk("res_fail", fail_cnt, 0);
        chk("res_cnt",  res_cnt, 1);

        // no resolution: 3 requests 106 cycles apart, then failure
        base_a = act_cnt;
        base_f = fail_cnt;
        bus.i_lookup_req = 1'b1;
        bus.i_lookup_ip  = 32'h0A000001;
        tick();
        bus.i_lookup_req = 1'b0;
        ticks(49);
        chk("to_act1",   act_cnt, base_a + 1);
        chk("to_retry0", 32'(bus.o_retry_cnt), 0);
        ticks(110);
        chk("to_act2",   act_cnt, base_a + 2);
        chk("to_retry1", 32'(bus.o_retry_cnt), 1);
        ticks(240);
        chk("to_act3",   act_cnt, base_a + 3);
        chk("to_fail",   fail_cnt, base_f + 1);
        chk("to_retry2", 32'(bus.o_retry_cnt), 2);
        chk("to_busy",   32'(bus.o_lookup_busy), 0);

        // reply detour in WAIT_RESP; timeout inside the reply frame retries right after it
        base_r = rpl_cnt;
        bus.i_lookup_req = 1'b1;
        bus.i_lookup_ip  = 32'h0A000002;
        tick();
        bus.i_lookup_req = 1'b0;
        ticks(101);
        bus.i_reply_req = 1'b1;
        tick();
        bus.i_reply_req = 1'b0;
        tick();
        chk("det_reply",   32'(bus.o_arp_reply), 1);
        ticks(6);
        chk("det_act_pre", 32'(bus.o_arp_active), 0);
        chk("det_retry",   32'(bus.o_retry_cnt), 1);
        tick();
        chk("det_act",     32'(bus.o_arp_active), 1);
        ticks(20);
        bus.i_resolve_valid = 1'b1;
        bus.i_resolve_ip    = 32'h0A000002;
        tick();
        bus.i_resolve_valid = 1'b0;
        chk("det_res",     32'(bus.o_resolved), 1);
        chk("retry_hold",  32'(bus.o_retry_cnt), 1);
        ticks(5);
        chk("det_busy",    32'(bus.o_lookup_busy), 0);
        chk("det_rpl_cnt", rpl_cnt, base_r + 1);

        // reply and lookup together: reply first; 3 pulses while pending give one reply
        base_r = rpl_cnt;
        base_s = res_cnt;
        bus.i_reply_req  = 1'b1;
        bus.i_lookup_req = 1'b1;
        bus.i_lookup_ip  = 32'h0B000001;
        tick();
        bus.i_reply_req  = 1'b0;
        bus.i_lookup_req = 1'b0;
        tick();
        chk("pri_reply",  32'(bus.o_arp_reply), 1);
        chk("pri_active", 32'(bus.o_arp_active), 0);
        ticks(6);
        chk("pri_req",    32'(bus.o_arp_active), 1);
        ticks(12);
        bus.i_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_reply_req = 1'b1;
            tick();
            bus.i_reply_req = 1'b0;
            tick();
        end
        chk("rdy_gate", 32'(bus.o_arp_reply), 0);
        bus.i_tx_ready = 1'b1;
        tick();
        chk("col_fire", 32'(bus.o_arp_reply), 1);
        ticks(10);
        chk("col_cnt",  rpl_cnt, base_r + 2);
        bus.i_resolve_valid = 1'b1;
        bus.i_resolve_ip    = 32'h0B000001;
        tick();
        bus.i_resolve_valid = 1'b0;
        ticks(5);
        chk("col_res",  res_cnt, base_s + 1);

        // asynchronous reset in the middle of a request frame
        bus.i_lookup_req = 1'b1;
        bus.i_lookup_ip  = 32'h0C000001;
        tick();
        bus.i_lookup_req = 1'b0;
        ticks(3);
        base_a = act_cnt;
        rst_n = 1'b0;
        #2;
        chk("arst_busy",   32'(bus.o_lookup_busy), 0);
        chk("arst_dst",    bus.o_arp_active_dst_ip, 0);
        chk("arst_active", 32'(bus.o_arp_active), 0);
        chk("arst_retry",  32'(bus.o_retry_cnt), 0);
        ticks(2);
        rst_n = 1'b1;
        ticks(20);
        chk("arst_idle",  act_cnt, base_a);
        chk("arst_busy2", 32'(bus.o_lookup_busy), 0);
        chk("no_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
